// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - run/pause/clear sequencer for an 8-bit T-flip-flop counter
// Divides clk into count ticks and emits one-cycle enable/clear pulses while shadowing the count.
module count_sequencer #(
    parameter int DIV_W = 26,
    parameter int DIV0  = 50000000,
    parameter int DIV1  = 25000000,
    parameter int DIV2  = 5000000,
    parameter int DIV3  = 1
) (
    input  logic       clk,
    input  logic       rset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       mode,
    input  logic [1:0] rate_sel,
    input  logic [7:0] limit,
    output logic       cnt_en,
    output logic       cnt_clr_n,
    output logic [7:0] count,
    output logic [1:0] state,
    output logic       done
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // Reload values are one less than the period: the div==0 edge is the tick itself.
    localparam logic [DIV_W-1:0] RELOAD0 = DIV_W'(DIV0 - 1);
    localparam logic [DIV_W-1:0] RELOAD1 = DIV_W'(DIV1 - 1);
    localparam logic [DIV_W-1:0] RELOAD2 = DIV_W'(DIV2 - 1);
    localparam logic [DIV_W-1:0] RELOAD3 = DIV_W'(DIV3 - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             clr_n_q, clr_n_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] reload;

    always_comb begin
        reload = RELOAD0;
        case (rate_sel)
            2'd0:    reload = RELOAD0;
            2'd1:    reload = RELOAD1;
            2'd2:    reload = RELOAD2;
            default: reload = RELOAD3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        en_d    = 1'b0;
        clr_n_d = 1'b1;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = 8'd0;
            div_d   = '0;
            clr_n_d = 1'b0;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            case (state_q)
                ST_IDLE: div_d = reload;
                ST_DONE: begin
                    div_d   = reload;
                    count_d = 8'd0;
                    clr_n_d = 1'b0;
                end
                default: div_d = div_q;
            endcase
        end else if (state_q == ST_RUN) begin
            if (div_q != '0) begin
                div_d = div_q - 1'b1;
            end else begin
                div_d = reload;
                // limit is compared live so lowering it below count terminates on this tick
                if (count_q < limit) begin
                    en_d    = 1'b1;
                    count_d = count_q + 8'd1;
                end else if (!mode) begin
                    clr_n_d = 1'b0;
                    count_d = 8'd0;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rset) begin
            state_q <= ST_IDLE;
            count_q <= 8'd0;
            div_q   <= '0;
            en_q    <= 1'b0;
            clr_n_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            en_q    <= en_d;
            clr_n_q <= clr_n_d;
            done_q  <= done_d;
        end
    end

    assign cnt_en    = en_q;
    assign cnt_clr_n = clr_n_q;
    assign count     = count_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - directed self-checking bench for count_sequencer
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rset, start, stop, clear, mode;
    logic [1:0] rate_sel;
    logic [7:0] limit;

    logic       cnt_en, cnt_clr_n, done;
    logic [7:0] count;
    logic [1:0] state;
    logic       cnt_en4, cnt_clr_n4, done4;
    logic [7:0] count4;
    logic [1:0] state4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_sequencer dut (
        .clk(clk), .rset(rset), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .rate_sel(rate_sel), .limit(limit),
        .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n), .count(count), .state(state), .done(done)
    );

    count_sequencer #(.DIV3(4)) dut4 (
        .clk(clk), .rset(rset), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .rate_sel(rate_sel), .limit(limit),
        .cnt_en(cnt_en4), .cnt_clr_n(cnt_clr_n4), .count(count4), .state(state4), .done(done4)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
    endtask

    initial begin
        rset = 1'b0; start = 1'b1; stop = 1'b0; clear = 1'b0;
        mode = 1'b0; rate_sel = 2'd3; limit = 8'd5;
        cyc();
        cyc();
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_en", cnt_en, 0);
        check("rst_clr_n", cnt_clr_n, 1);
        check("rst_done", done, 0);

        // wrap at limit=5, tick every cycle
        start = 1'b0;
        rset  = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("wrap_run_state", state, 1);
        check("wrap_first_en", cnt_en, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check($sformatf("wrap_en_%0d", i), cnt_en, 1);
            check($sformatf("wrap_cnt_%0d", i), count, i);
        end
        cyc();
        check("wrap_clr_n", cnt_clr_n, 0);
        check("wrap_clr_cnt", count, 0);
        check("wrap_clr_en", cnt_en, 0);
        cyc();
        check("wrap_resume_en", cnt_en, 1);
        check("wrap_resume_cnt", count, 1);

        // clear pulse and IDLE
        clear = 1'b1;
        cyc();
        check("clr_state", state, 0);
        check("clr_pulse", cnt_clr_n, 0);
        check("clr_count", count, 0);
        clear = 1'b0;
        cyc();
        check("clr_release", cnt_clr_n, 1);
        check("idle_no_en", cnt_en, 0);

        // stop at limit=3
        mode = 1'b1; limit = 8'd3;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check($sformatf("stop_cnt_%0d", i), count, i);
        end
        cyc();
        check("done_state", state, 3);
        check("done_flag", done, 1);
        check("done_no_en", cnt_en, 0);
        check("done_no_clr", cnt_clr_n, 1);
        cyc();
        check("done_hold_en", cnt_en, 0);
        check("done_hold_cnt", count, 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("restart_state", state, 1);
        check("restart_clr", cnt_clr_n, 0);
        check("restart_cnt", count, 0);
        check("restart_done", done, 0);
        cyc();
        check("restart_tick", count, 1);

        // limit=0 with mode=1 terminates on first tick
        do_clear();
        limit = 8'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("lim0_done", state, 3);
        check("lim0_no_en", cnt_en, 0);

        // clear beats start while running at count 7
        do_clear();
        mode = 1'b0; limit = 8'd20;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        check("pre_clear_cnt", count, 7);
        clear = 1'b1; start = 1'b1;
        cyc();
        check("cs_state", state, 0);
        check("cs_count", count, 0);
        check("cs_clr", cnt_clr_n, 0);
        check("cs_en", cnt_en, 0);
        clear = 1'b0; start = 1'b0;
        cyc();
        check("cs_after_clr", cnt_clr_n, 1);
        check("cs_after_en", cnt_en, 0);

        // lowering limit below count
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("lower_pre_cnt", count, 10);
        limit = 8'd4;
        cyc();
        check("lower_clr", cnt_clr_n, 0);
        check("lower_cnt", count, 0);
        check("lower_en", cnt_en, 0);

        // divide-by-4 instance: latency, pause and resume
        limit = 8'd20;
        do_clear();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check($sformatf("d4_en_k%0d", i), cnt_en4, (i == 4) ? 1 : 0);
        end
        stop = 1'b1;
        cyc();
        check("d4_pause_state", state4, 2);
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("d4_pause_en_%0d", i), cnt_en4, 0);
        end
        check("d4_pause_cnt", count4, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("d4_resume_state", state4, 1);
        cyc();
        check("d4_res_en1", cnt_en4, 0);
        cyc();
        check("d4_res_en2", cnt_en4, 0);
        cyc();
        check("d4_res_en3", cnt_en4, 1);
        check("d4_res_cnt", count4, 2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("d4_gap_%0d", i), cnt_en4, 0);
        end
        cyc();
        check("d4_period_en", cnt_en4, 1);

        // reset mid-run overrides start
        rset = 1'b0; start = 1'b1;
        cyc();
        check("mid_rst_state", state, 0);
        check("mid_rst_cnt", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
